// File: rtl/wf_pending_tracker_pkg.sv
// Shared sizing for the per-wavefront pending tracker.
// Issue and the LSU must use these same constants.
package wf_pending_tracker_pkg;

  localparam int unsigned NUM_WF = 40;
  localparam int unsigned WFID_W = 6;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-wavefront event decode presented to one counter cell.
  typedef struct packed {
    logic inc;
    logic dec;
    logic fl;
  } wf_evt_t;

endpackage

// File: rtl/wf_pending_cell.sv
// One wavefront's saturating outstanding-op counter.
// Exposes its next-state so the top can register derived outputs.
module wf_pending_cell
  import wf_pending_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             fl,
  output logic [CNT_W-1:0] next_cnt_c,
  output logic             busy_c,
  output logic             ovf_evt_c,
  output logic             udf_evt_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= next_cnt_c;
    end
  end

  // Flush wins; a same-cycle issue survives the flush, a retire does not.
  always_comb begin
    next_cnt_c = cnt;
    ovf_evt_c  = 1'b0;
    udf_evt_c  = 1'b0;
    if (fl) begin
      next_cnt_c = inc ? CNT_W'(1) : '0;
    end else if (inc && dec) begin
      next_cnt_c = cnt;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        ovf_evt_c = 1'b1;
      end else begin
        next_cnt_c = cnt + CNT_W'(1);
      end
    end else if (dec) begin
      if (cnt == '0) begin
        udf_evt_c = 1'b1;
      end else begin
        next_cnt_c = cnt - CNT_W'(1);
      end
    end
  end

  assign busy_c = (next_cnt_c != '0);

endmodule

// File: rtl/wf_pending_tracker.sv
// Per-wavefront outstanding-operation tracker for the issue stage.
// Decodes issue/retire/flush ids into counter cells and registers busy, query and error state.
module wf_pending_tracker
  import wf_pending_tracker_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [WFID_W-1:0] issue_wfid,
  input  logic              retire_valid,
  input  logic [WFID_W-1:0] retire_wfid,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  input  logic [WFID_W-1:0] query_wfid,
  output logic [CNT_W-1:0]  query_cnt,
  output logic [NUM_WF-1:0] pending_busy,
  output logic              err_overflow,
  output logic              err_underflow
);

  wf_evt_t          evt [NUM_WF];
  logic [CNT_W-1:0] next_cnt [NUM_WF];
  logic [NUM_WF-1:0] busy_c;
  logic [NUM_WF-1:0] ovf_c;
  logic [NUM_WF-1:0] udf_c;
  logic [CNT_W-1:0] query_cnt_c;

  // Ids at or above NUM_WF match no cell, so they are silently dropped.
  for (genvar i = 0; i < int'(NUM_WF); i++) begin : g_cell
    assign evt[i].inc = issue_valid  && (issue_wfid  == WFID_W'(i));
    assign evt[i].dec = retire_valid && (retire_wfid == WFID_W'(i));
    assign evt[i].fl  = flush_valid  && (flush_wfid  == WFID_W'(i));

    wf_pending_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .inc        (evt[i].inc),
      .dec        (evt[i].dec),
      .fl         (evt[i].fl),
      .next_cnt_c (next_cnt[i]),
      .busy_c     (busy_c[i]),
      .ovf_evt_c  (ovf_c[i]),
      .udf_evt_c  (udf_c[i])
    );
  end

  always_comb begin
    query_cnt_c = '0;
    for (int unsigned i = 0; i < NUM_WF; i++) begin
      if (query_wfid == WFID_W'(i)) begin
        query_cnt_c = next_cnt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      query_cnt     <= '0;
      pending_busy  <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      query_cnt     <= query_cnt_c;
      pending_busy  <= busy_c;
      err_overflow  <= err_overflow  | (|ovf_c);
      err_underflow <= err_underflow | (|udf_c);
    end
  end

endmodule

// File: tb/tb_wf_pending_tracker.sv
// Directed scoreboard bench for wf_pending_tracker: the driver queues hand-computed
// expectations per cycle, a monitor pops and compares after each clock edge.
module tb_wf_pending_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [5:0]  issue_wfid;
  logic        retire_valid;
  logic [5:0]  retire_wfid;
  logic        flush_valid;
  logic [5:0]  flush_wfid;
  logic [5:0]  query_wfid;
  logic [3:0]  query_cnt;
  logic [39:0] pending_busy;
  logic        err_overflow;
  logic        err_underflow;

  typedef struct {
    string       name;
    logic [3:0]  cnt;
    logic [39:0] busy;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [39:0] B0 = 40'd1;
  localparam logic [39:0] B3 = 40'd1 << 3;
  localparam logic [39:0] B4 = 40'd1 << 4;
  localparam logic [39:0] B5 = 40'd1 << 5;
  localparam logic [39:0] B7 = 40'd1 << 7;
  localparam logic [39:0] B9 = 40'd1 << 9;

  wf_pending_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_wfid    (issue_wfid),
    .retire_valid  (retire_valid),
    .retire_wfid   (retire_wfid),
    .flush_valid   (flush_valid),
    .flush_wfid    (flush_wfid),
    .query_wfid    (query_wfid),
    .query_cnt     (query_cnt),
    .pending_busy  (pending_busy),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
  task automatic step(input string name, input logic r,
                      input logic iv, input int iw, input logic rv, input int rw,
                      input logic fv, input int fw, input int qw,
                      input int ec, input logic [39:0] eb, input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    rst          = r;
    issue_valid  = iv;
    issue_wfid   = 6'(iw);
    retire_valid = rv;
    retire_wfid  = 6'(rw);
    flush_valid  = fv;
    flush_wfid   = 6'(fw);
    query_wfid   = 6'(qw);
    e.name = name;
    e.cnt  = 4'(ec);
    e.busy = eb;
    e.ovf  = eo;
    e.udf  = eu;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string what, input logic [39:0] act,
                     input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", name, what, act, req);
    end
  endtask

  // Monitor: the outputs after each edge answer the oldest queued stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        #1;
        cmp(e.name, "query_cnt",     40'(query_cnt),     40'(e.cnt));
        cmp(e.name, "pending_busy",  pending_busy,       e.busy);
        cmp(e.name, "err_overflow",  40'(err_overflow),  40'(e.ovf));
        cmp(e.name, "err_underflow", 40'(err_underflow), 40'(e.udf));
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; issue_valid = 1'b0; issue_wfid = '0; retire_valid = 1'b0;
    retire_wfid = '0; flush_valid = 1'b0; flush_wfid = '0; query_wfid = '0;

    // Reset overrides events presented in the same cycle.
    step("rst_evt",  1, 1, 5, 1, 2, 1, 1, 5, 0, '0, 0, 0);
    step("rst_hold", 1, 1, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0);

    step("wf5_i1", 0, 1, 5, 0, 0, 0, 0, 5, 1, B5, 0, 0);
    step("wf5_i2", 0, 1, 5, 0, 0, 0, 0, 5, 2, B5, 0, 0);
    step("wf5_i3", 0, 1, 5, 0, 0, 0, 0, 5, 3, B5, 0, 0);
    step("wf5_r1", 0, 0, 0, 1, 5, 0, 0, 5, 2, B5, 0, 0);
    step("wf5_r2", 0, 0, 0, 1, 5, 0, 0, 5, 1, B5, 0, 0);
    step("wf5_r3", 0, 0, 0, 1, 5, 0, 0, 5, 0, '0, 0, 0);
    step("wf5_idle", 0, 0, 0, 0, 0, 0, 0, 5, 0, '0, 0, 0);

    step("wf7_i1",  0, 1, 7, 0, 0, 0, 0, 7, 1, B7, 0, 0);
    step("wf7_i2",  0, 1, 7, 0, 0, 0, 0, 7, 2, B7, 0, 0);
    step("wf7_ir",  0, 1, 7, 1, 7, 0, 0, 7, 2, B7, 0, 0);
    step("wf4_i1",  0, 1, 4, 0, 0, 0, 0, 4, 1, B7 | B4, 0, 0);
    step("i3_r4",   0, 1, 3, 1, 4, 0, 0, 3, 1, B7 | B3, 0, 0);
    step("wf4_q",   0, 0, 0, 0, 0, 0, 0, 4, 0, B7 | B3, 0, 0);

    for (int k = 1; k <= 4; k++)
      step("wf9_inc", 0, 1, 9, 0, 0, 0, 0, 9, k, B3 | B7 | B9, 0, 0);
    step("fl9_ret", 0, 0, 0, 1, 9, 1, 9, 9, 0, B3 | B7, 0, 0);
    step("fl9_iss", 0, 1, 9, 0, 0, 1, 9, 9, 1, B3 | B7 | B9, 0, 0);
    step("fl9_only", 0, 0, 0, 0, 0, 1, 9, 9, 0, B3 | B7, 0, 0);

    step("oor_all", 0, 1, 40, 1, 63, 1, 50, 3, 1, B3 | B7, 0, 0);
    step("oor_ret", 0, 0, 0, 1, 41, 0, 0, 7, 2, B3 | B7, 0, 0);
    step("oor_iss", 0, 1, 63, 0, 0, 1, 40, 7, 2, B3 | B7, 0, 0);

    step("wf1_ir0", 0, 1, 1, 1, 1, 0, 0, 1, 0, B3 | B7, 0, 0);

    for (int k = 1; k <= 16; k++)
      step("wf0_sat", 0, 1, 0, 0, 0, 0, 0, 0, (k > 15) ? 15 : k, B0 | B3 | B7,
           (k == 16) ? 1'b1 : 1'b0, 0);

    step("wf1_udf",  0, 0, 0, 1, 1, 0, 0, 1, 0, B0 | B3 | B7, 1, 1);
    step("sticky_a", 0, 0, 0, 0, 0, 0, 0, 0, 15, B0 | B3 | B7, 1, 1);
    step("sticky_b", 0, 0, 0, 0, 0, 0, 0, 7, 2, B0 | B3 | B7, 1, 1);
    step("wf0_irmax", 0, 1, 0, 1, 0, 0, 0, 0, 15, B0 | B3 | B7, 1, 1);

    step("rst_mid",  1, 1, 3, 0, 0, 0, 0, 3, 0, '0, 0, 0);
    step("post_rst_ret", 0, 0, 0, 1, 7, 0, 0, 7, 0, '0, 0, 1);
    step("post_rst_q0",  0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 1);

    @(negedge clk);
    issue_valid = 1'b0; retire_valid = 1'b0; flush_valid = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
